tick_generator: RTL and testbench

//  Parametrised timebase for the countdown timer: divides clk to a 1 s tick,

---
 rtl/tick_generator.sv | 65 ++++++
 tb/tb_tick_generator.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/tick_generator.sv
// Countdown-timer timebase: divides clk to a 1 s tick, counts seconds, pulses a minute tick on wrap.
// Optional test mode (fast port, FAST_DIV divide) is enabled by defining TICK_TEST_EN.
module tick_generator #(
   parameter int CLK_HZ      = 16_000_000,
   parameter int SEC_PER_MIN = 60,
   parameter int FAST_DIV    = 16,
   localparam int PRE_W      = $clog2(CLK_HZ),
   localparam int SEC_W      = $clog2(SEC_PER_MIN)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
`ifdef TICK_TEST_EN
   input  logic             fast,
`endif
   output logic             sec_tick,
   output logic             min_tick,
   output logic [SEC_W-1:0] sec_count
);

   localparam logic [PRE_W-1:0] TERM_SLOW = PRE_W'(CLK_HZ - 1);
   localparam logic [SEC_W-1:0] SEC_LAST  = SEC_W'(SEC_PER_MIN - 1);

   logic [PRE_W-1:0] prescaler;
   logic [PRE_W-1:0] term;
   logic             pre_wrap;

`ifdef TICK_TEST_EN
   localparam logic [PRE_W-1:0] TERM_FAST = PRE_W'(FAST_DIV - 1);
   assign term = fast ? TERM_FAST : TERM_SLOW;
`else
   assign term = TERM_SLOW;
`endif

   // >= rather than == so a switch to the short divide mid-second wraps on the next edge
   assign pre_wrap = (prescaler >= term);

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         prescaler <= '0;
         sec_count <= '0;
         sec_tick  <= 1'b0;
         min_tick  <= 1'b0;
      end else if (!en) begin
         sec_tick  <= 1'b0;
         min_tick  <= 1'b0;
      end else if (pre_wrap) begin
         prescaler <= '0;
         sec_tick  <= 1'b1;
         if (sec_count == SEC_LAST) begin
            sec_count <= '0;
            min_tick  <= 1'b1;
         end else begin
            sec_count <= sec_count + 1'b1;
            min_tick  <= 1'b0;
         end
      end else begin
         prescaler <= prescaler + 1'b1;
         sec_tick  <= 1'b0;
         min_tick  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tick_generator.sv
// Scoreboard bench for tick_generator: driver pushes model predictions, negedge monitor pops and compares.
module tb_tick_generator;

   localparam int CLK_HZ = 10;
   localparam int SPM    = 3;
   localparam int FDIV   = 4;

   typedef struct packed {
      logic       s;
      logic       m;
      logic [1:0] c;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n, en, clr, fast;
   logic       sec_tick, min_tick;
   logic [1:0] sec_count;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   sec_pulses = 0;
   int   min_pulses = 0;
   logic prev_sec = 1'b0;

   // reference model state: enabled edges into the current second, seconds into the minute
   int   m_phase = 0;
   int   m_secs  = 0;
   exp_t sb_q[$];

   tick_generator #(.CLK_HZ(CLK_HZ), .SEC_PER_MIN(SPM), .FAST_DIV(FDIV)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .clr       (clr),
`ifdef TICK_TEST_EN
      .fast      (fast),
`endif
      .sec_tick  (sec_tick),
      .min_tick  (min_tick),
      .sec_count (sec_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // one clock edge: apply inputs, predict post-edge outputs, advance to 1 time unit after the edge
   task automatic step(input bit r, input bit c, input bit e, input bit f);
      exp_t x;
      int   div;
      rst_n = r; clr = c; en = e; fast = f;
      x = '0;
`ifdef TICK_TEST_EN
      div = f ? FDIV : CLK_HZ;
`else
      div = CLK_HZ;
`endif
      if (!r || c) begin
         m_phase = 0;
         m_secs  = 0;
      end else if (e) begin
         if (m_phase + 1 >= div) begin
            m_phase = 0;
            m_secs  = (m_secs + 1) % SPM;
            x.s = 1'b1;
            x.m = (m_secs == 0);
         end else begin
            m_phase++;
         end
      end
      x.c = 2'(m_secs);
      sb_q.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n, input bit f);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b1, f);
   endtask

   always @(negedge clk) begin
      if (sb_q.size() != 0) begin
         exp_t x;
         x = sb_q.pop_front();
         chk("sec_tick",  int'(sec_tick),  int'(x.s));
         chk("min_tick",  int'(min_tick),  int'(x.m));
         chk("sec_count", int'(sec_count), int'(x.c));
         if (min_tick === 1'b1) chk("min_with_sec", int'(sec_tick), 1);
         if (prev_sec === 1'b1) chk("no_back_to_back", int'(sec_tick), 0);
         prev_sec = sec_tick;
         if (sec_tick === 1'b1) sec_pulses++;
         if (min_tick === 1'b1) min_pulses++;
      end
   end

   initial begin
      rst_n = 1'b0; clr = 1'b0; en = 1'b0; fast = 1'b0;
      // reset, then free-run one minute: ticks after edges 10,20,30
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      run(30, 1'b0);

      // freeze for 5 edges at prescaler 4
      step(1'b1, 1'b1, 1'b0, 1'b0);
      run(4, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
      run(20, 1'b0);

      // clear mid-second at prescaler 7, sec_count 2
      step(1'b1, 1'b1, 1'b0, 1'b0);
      run(27, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      run(12, 1'b0);

      // clear, then reset, each on the wrap edge
      step(1'b1, 1'b1, 1'b0, 1'b0);
      run(9, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      run(9, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      run(5, 1'b0);

      // two full minutes: 6 second pulses, 2 minute pulses
      step(1'b1, 1'b1, 1'b1, 1'b0);
      sec_pulses = 0;
      min_pulses = 0;
      run(CLK_HZ * SPM * 2, 1'b0);
      @(negedge clk); #1;
      chk("two_min_sec_pulses", sec_pulses, 6);
      chk("two_min_min_pulses", min_pulses, 2);

`ifdef TICK_TEST_EN
      // fast from clear, then fast raised at prescaler 6
      step(1'b1, 1'b1, 1'b1, 1'b1);
      run(24, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      run(6, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      run(8, 1'b1);
`endif

      // randomized traffic
      begin
         bit rf;
         rf = 1'b0;
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) rf = ~rf;
            step($urandom_range(0, 199) != 0, $urandom_range(0, 99) == 0,
                 $urandom_range(0, 9) != 0, rf);
         end
      end

      @(negedge clk); #1;
      chk("scoreboard_drained", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
